bpm_beat_synth: RTL and testbench
=================================

# bpm_beat_synth

Synthesizable beat-pattern source that drives a `signal_rms`/`signal_rms_valid` stream of periodic energy spikes at a programmed tempo. It is the transmit-side counterpart of `bpm_energy_detector`. It provides on-chip self-test of the detector path and a metronome reference for the display. A BPM value is converted to a beat period by a sequential restoring divider, and a phase counter then emits spike bursts over a baseline level.

## Interface
- `SAMPLE_WIDTH`, 16: width of `signal_rms`, `spike_amp` and `base_amp`.
- `CLOCK_FREQ`, 50_000_000: clock rate in Hz. `CLOCK_FREQ*60` must fit in 32 bits.
- `BPM_WIDTH`, 16: width of `bpm_target` and `bpm_active`.
- `SAMPLE_DIV`, 1: clock cycles per output sample. Must be ≥1.
- `SPIKE_SAMPLES`, 5: number of samples held at `spike_amp` per beat. Must be ≥1.
- `MIN_BPM` / `MAX_BPM`, 40 / 200: accepted tempo range, inclusive.
- `clk`, input, 1: single clock for all logic.
- `reset`, input, 1: synchronous, active-high.
- `enable`, input, 1: run the stream.
- `bpm_target`, input, BPM_WIDTH: requested tempo.
- `bpm_load`, input, 1: one-cycle strobe that samples `bpm_target`.
- `spike_amp`, input, SAMPLE_WIDTH: sample level during a spike.
- `base_amp`, input, SAMPLE_WIDTH: sample level between spikes.
- `signal_rms`, output, SAMPLE_WIDTH: sample value.
- `signal_rms_valid`, output, 1: sample strobe.
- `beat_out`, output, 1: one-cycle pulse at the start of each spike.
- `busy`, output, 1: divider running.
- `bpm_reject`, output, 1: one-cycle pulse when a load is refused.
- `bpm_active`, output, BPM_WIDTH: tempo currently in effect. 0 means none.

## Operation
- **Load path.**
  - A load is accepted when `bpm_load` is high, `busy` is low, and MIN_BPM ≤ `bpm_target` ≤ MAX_BPM.
  - Any other load is refused: `bpm_reject` pulses for one cycle, and all state is unchanged.
- **Divider.** The divider computes `floor(CLOCK_FREQ*60 / bpm_target)` with a 32-bit restoring algorithm, one quotient bit per cycle.
- **Period register.**
  - A completed quotient goes into `pending_period`.
  - If no period is valid, or `enable` is low, the quotient is committed immediately.
  - Otherwise it is committed at the next phase wrap, so the beat in progress completes at the old period.
  - `bpm_active` updates in the same cycle the period is committed.
- **Phase counter.**
  - Runs only while `enable` is high and a period is valid. It counts 0 to period−1, then wraps.
  - Phase == 0 is a beat: `beat_out` = 1, and the spike counter loads SPIKE_SAMPLES.
  - The sample-tick counter also restarts on a beat, so the beat cycle is always a sample tick.
- **Samples.**
  - While `enable` is high, `signal_rms_valid` = 1 on each sample tick, every SAMPLE_DIV cycles.
  - `signal_rms` is `spike_amp` while the spike counter is nonzero (the counter decrements per tick), and `base_amp` otherwise.
  - With no valid period, the stream is baseline only and `beat_out` never fires.
- **Spike overlapping a beat.** If a beat arrives while a spike is still active (only possible when the period is less than SPIKE_SAMPLES×SAMPLE_DIV), the spike counter reloads.
- **Disable.** When `enable` is low, the phase, spike counter and tick counter are held at 0. `signal_rms_valid` and `beat_out` are 0, and `signal_rms` holds its last value. The period register and the divider are unaffected.
- **Reset** clears everything: the period becomes invalid and any divide in progress is aborted.
- **State machine:** IDLE → DIV (32 cycles) → IDLE. Run-side states are NOPERIOD and RUN; a period commit moves NOPERIOD → RUN. Only reset returns to NOPERIOD.

## Timing
- All outputs are registered.
- Reset values: `signal_rms` = 0, `signal_rms_valid` = 0, `beat_out` = 0, `busy` = 0, `bpm_reject` = 0, `bpm_active` = 0.
- Load latency:
  - `bpm_load` is sampled in cycle t.
  - `busy` is high for cycles t+1 through t+32.
  - The quotient is available at t+33.
- First beat: with no prior period and `enable` high, the first beat occurs at t+34 (the first cycle after commit with phase 0).
- Enabling: when `enable` rises in cycle e with a valid period, `beat_out` and the first spike sample appear in cycle e+1.
- Beat spacing: consecutive `beat_out` pulses are exactly period cycles apart.
- Spike length: a spike spans SPIKE_SAMPLES valid samples, which is SPIKE_SAMPLES×SAMPLE_DIV cycles.
- Disable latency: `enable` falling in cycle d gives `signal_rms_valid` = 0 from d+1.
- Reject: `bpm_reject` is asserted in the cycle after the refused `bpm_load`.
- Simultaneous events: a load arriving in the same cycle as a divider completion is refused, because `busy` is still high.

## Test plan
All scenarios use `CLOCK_FREQ`=1000, `SAMPLE_DIV`=1, `SPIKE_SAMPLES`=5, `spike_amp`=3000, `base_amp`=100.
- **Reset and no period.** Assert reset, then hold `enable`=1 with no load → all outputs 0 during reset; afterwards `signal_rms_valid`=1 every cycle with `signal_rms`=100, and no `beat_out`.
- **Load 120.** `bpm_target`=120 with `bpm_load` → `busy` high for 32 cycles, `bpm_active`=120, `beat_out` every 500 cycles, each spike 5 samples of 3000 followed by 100.
- **Change tempo mid-run.** Load 60 mid-period → the current 500-cycle interval completes, later intervals are 1000 cycles, and `bpm_active` switches at the wrap. Then load 180 → 333-cycle intervals.
- **Refused loads.** Load 30, load 250, and a load during `busy` → each gives a one-cycle `bpm_reject`, with `bpm_active` and beat spacing unchanged.
- **Disable mid-spike.** Drop `enable` during the 3rd spike sample → `signal_rms_valid`=0 on the next cycle. Re-enable → `beat_out` one cycle later, followed by a full 5-sample spike.
- **Reset mid-divide.** Assert reset during DIV → `busy`=0 and `bpm_active`=0 on the next cycle, with no `beat_out` afterwards.

Source files
------------

// File: rtl/bpm_beat_synth.sv
// bpm_beat_synth: periodic energy-spike stream generator.
// A tempo in BPM is turned into a beat period (in clocks) by a 32-step
// restoring divider; a phase counter then emits a spike burst of
// SPIKE_SAMPLES samples at spike_amp on every beat, base_amp otherwise.
module bpm_beat_synth #(
    parameter int SAMPLE_WIDTH  = 16,
    parameter int CLOCK_FREQ    = 50_000_000,
    parameter int BPM_WIDTH     = 16,
    parameter int SAMPLE_DIV    = 1,
    parameter int SPIKE_SAMPLES = 5,
    parameter int MIN_BPM       = 40,
    parameter int MAX_BPM       = 200
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [BPM_WIDTH-1:0]    bpm_target,
    input  logic                    bpm_load,
    input  logic [SAMPLE_WIDTH-1:0] spike_amp,
    input  logic [SAMPLE_WIDTH-1:0] base_amp,
    output logic [SAMPLE_WIDTH-1:0] signal_rms,
    output logic                    signal_rms_valid,
    output logic                    beat_out,
    output logic                    busy,
    output logic                    bpm_reject,
    output logic [BPM_WIDTH-1:0]    bpm_active
);

    localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int SPK_W  = $clog2(SPIKE_SAMPLES + 1);
    localparam logic [31:0]          DIVIDEND   = 32'(64'(CLOCK_FREQ) * 64'd60);
    localparam logic [BPM_WIDTH-1:0] MIN_B      = BPM_WIDTH'(MIN_BPM);
    localparam logic [BPM_WIDTH-1:0] MAX_B      = BPM_WIDTH'(MAX_BPM);
    localparam logic [TICK_W-1:0]    TICK_FIRST = TICK_W'((SAMPLE_DIV > 1) ? 1 : 0);
    localparam logic [TICK_W-1:0]    TICK_LAST  = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [SPK_W-1:0]     SPK_RELOAD = SPK_W'(SPIKE_SAMPLES - 1);

    typedef enum logic {D_IDLE, D_DIV} div_state_t;
    typedef enum logic {R_NOPERIOD, R_RUN} run_state_t;

    div_state_t              div_st_q, div_st_d;
    run_state_t              run_st_q, run_st_d;
    logic [31:0]             dvs_q, dvs_d, rem_q, rem_d, quo_q, quo_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [BPM_WIDTH-1:0]    div_bpm_q, div_bpm_d;
    logic [31:0]             period_q, period_d, pend_q, pend_d;
    logic [BPM_WIDTH-1:0]    pend_bpm_q, pend_bpm_d, bpm_active_q, bpm_active_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [31:0]             phase_q, phase_d;
    logic [SPK_W-1:0]        spike_q, spike_d;
    logic [TICK_W-1:0]       tick_q, tick_d;
    logic [SAMPLE_WIDTH-1:0] rms_q, rms_d;
    logic                    vld_q, vld_d, beat_q, beat_d, reject_q, reject_d;
    logic                    in_range, div_done, beat, tick, wrap;
    logic [32:0]             rem_sh;
    logic [31:0]             div_quot;

    // Load acceptance and the restoring divider, one quotient bit per cycle.
    always_comb begin
        div_st_d  = div_st_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        div_bpm_d = div_bpm_q;
        reject_d  = 1'b0;
        div_done  = 1'b0;
        in_range  = (bpm_target >= MIN_B) && (bpm_target <= MAX_B);
        rem_sh    = {rem_q, quo_q[31]};
        div_quot  = quo_q;
        case (div_st_q)
            D_IDLE: begin
                if (bpm_load) begin
                    if (in_range) begin
                        div_st_d  = D_DIV;
                        dvs_d     = 32'(bpm_target);
                        rem_d     = '0;
                        quo_d     = DIVIDEND;
                        cnt_d     = '0;
                        div_bpm_d = bpm_target;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            default: begin
                reject_d = bpm_load;
                if (rem_sh >= {1'b0, dvs_q}) begin
                    rem_d = 32'(rem_sh - {1'b0, dvs_q});
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_sh[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d    = cnt_q + 5'd1;
                div_quot = quo_d;
                if (cnt_q == 5'd31) begin
                    div_st_d = D_IDLE;
                    div_done = 1'b1;
                end
            end
        endcase
    end

    // Period commit policy, phase counter, sample ticks and spike shaping.
    always_comb begin
        run_st_d     = run_st_q;
        period_d     = period_q;
        bpm_active_d = bpm_active_q;
        pend_d       = pend_q;
        pend_bpm_d   = pend_bpm_q;
        pend_vld_d   = pend_vld_q;
        phase_d      = phase_q;
        spike_d      = spike_q;
        tick_d       = tick_q;
        rms_d        = rms_q;
        vld_d        = 1'b0;
        beat_d       = 1'b0;
        beat         = 1'b0;
        tick         = 1'b0;
        wrap         = (run_st_q == R_RUN) && enable && (phase_q == period_q - 32'd1);
        case (run_st_q)
            R_NOPERIOD: begin
                if (div_done) begin
                    period_d     = div_quot;
                    bpm_active_d = div_bpm_q;
                    run_st_d     = R_RUN;
                end
            end
            default: begin
                if (div_done) begin
                    if (!enable || wrap) begin
                        period_d     = div_quot;
                        bpm_active_d = div_bpm_q;
                        pend_vld_d   = 1'b0;
                    end else begin
                        pend_d     = div_quot;
                        pend_bpm_d = div_bpm_q;
                        pend_vld_d = 1'b1;
                    end
                end else if (pend_vld_q && (!enable || wrap)) begin
                    period_d     = pend_q;
                    bpm_active_d = pend_bpm_q;
                    pend_vld_d   = 1'b0;
                end
            end
        endcase
        if (!enable) begin
            phase_d = '0;
            spike_d = '0;
            tick_d  = '0;
        end else begin
            beat = (run_st_q == R_RUN) && (phase_q == 32'd0);
            tick = beat || (tick_q == '0);
            if (run_st_q == R_RUN)
                phase_d = wrap ? 32'd0 : phase_q + 32'd1;
            if (tick)
                tick_d = TICK_FIRST;
            else if (tick_q == TICK_LAST)
                tick_d = '0;
            else
                tick_d = tick_q + TICK_W'(1);
            beat_d = beat;
            if (tick) begin
                vld_d = 1'b1;
                if (beat) begin
                    rms_d   = spike_amp;
                    spike_d = SPK_RELOAD;
                end else if (spike_q != '0) begin
                    rms_d   = spike_amp;
                    spike_d = spike_q - SPK_W'(1);
                end else begin
                    rms_d = base_amp;
                end
            end
        end
    end

    // Control and output state, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_st_q     <= D_IDLE;
            run_st_q     <= R_NOPERIOD;
            cnt_q        <= '0;
            pend_vld_q   <= 1'b0;
            bpm_active_q <= '0;
            phase_q      <= '0;
            spike_q      <= '0;
            tick_q       <= '0;
            rms_q        <= '0;
            vld_q        <= 1'b0;
            beat_q       <= 1'b0;
            reject_q     <= 1'b0;
        end else begin
            div_st_q     <= div_st_d;
            run_st_q     <= run_st_d;
            cnt_q        <= cnt_d;
            pend_vld_q   <= pend_vld_d;
            bpm_active_q <= bpm_active_d;
            phase_q      <= phase_d;
            spike_q      <= spike_d;
            tick_q       <= tick_d;
            rms_q        <= rms_d;
            vld_q        <= vld_d;
            beat_q       <= beat_d;
            reject_q     <= reject_d;
        end
    end

    // Datapath registers; only meaningful when qualified by the state above.
    always_ff @(posedge clk) begin
        dvs_q      <= dvs_d;
        rem_q      <= rem_d;
        quo_q      <= quo_d;
        div_bpm_q  <= div_bpm_d;
        period_q   <= period_d;
        pend_q     <= pend_d;
        pend_bpm_q <= pend_bpm_d;
    end

    assign signal_rms       = rms_q;
    assign signal_rms_valid = vld_q;
    assign beat_out         = beat_q;
    assign busy             = (div_st_q == D_DIV);
    assign bpm_reject       = reject_q;
    assign bpm_active       = bpm_active_q;

endmodule

// File: tb/tb_bpm_beat_synth.sv
// Testbench for bpm_beat_synth: scripted tempo scenarios with a beat-time
// scoreboard and a per-sample spike/baseline monitor.
module tb_bpm_beat_synth;

    localparam int SW = 16;
    localparam int BW = 16;
    localparam int SPK = 5;
    localparam int SPIKE = 3000;
    localparam int BASE = 100;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic [BW-1:0] bpm_target = '0;
    logic          bpm_load = 1'b0;
    logic [SW-1:0] spike_amp = SW'(SPIKE);
    logic [SW-1:0] base_amp = SW'(BASE);
    logic [SW-1:0] signal_rms;
    logic          signal_rms_valid, beat_out, busy, bpm_reject;
    logic [BW-1:0] bpm_active;

    bpm_beat_synth #(
        .SAMPLE_WIDTH(SW), .CLOCK_FREQ(1000), .BPM_WIDTH(BW), .SAMPLE_DIV(1),
        .SPIKE_SAMPLES(SPK), .MIN_BPM(40), .MAX_BPM(200)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .bpm_target(bpm_target),
        .bpm_load(bpm_load), .spike_amp(spike_amp), .base_amp(base_amp),
        .signal_rms(signal_rms), .signal_rms_valid(signal_rms_valid),
        .beat_out(beat_out), .busy(busy), .bpm_reject(bpm_reject),
        .bpm_active(bpm_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic en_s = 1'b0;
    logic rst_s = 1'b1;
    bit mon_on = 1'b0;
    int exp_beats[$];

    typedef struct {
        int bpm;
        bit rej;
        int period;
    } rec_t;
    rec_t tbl[8];

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        en_s  <= enable;
        rst_s <= reset;
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic go(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic peek(input int c);
        go(c);
        @(negedge clk);
    endtask

    task automatic load(input int bpm);
        bpm_target = BW'(bpm);
        bpm_load = 1'b1;
        @(posedge clk);
        #1;
        bpm_load = 1'b0;
    endtask

    task automatic push_beats(input int start, input int period, input int n);
        for (int k = 0; k < n; k++) exp_beats.push_back(start + k * period);
    endtask

    // Per-cycle monitor: beat timing from the scoreboard, valid/level from a spike model.
    initial begin
        int since;
        bit exp_beat, exp_vld;
        int exp_rms;
        since = SPK;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                exp_beat = (exp_beats.size() > 0) && (exp_beats[0] == cyc);
                check("beat_out", int'(beat_out), int'(exp_beat));
                if (exp_beat) void'(exp_beats.pop_front());
                exp_vld = en_s && !rst_s;
                check("valid", int'(signal_rms_valid), int'(exp_vld));
                if (exp_vld) begin
                    exp_rms = (exp_beat || since < SPK) ? SPIKE : BASE;
                    check("rms", int'(signal_rms), exp_rms);
                end
                if (!exp_vld) since = SPK;
                else if (exp_beat) since = 1;
                else if (since < SPK) since++;
            end
        end
    end

    initial begin
        int t, t1, b0, b2, bc, e, exp_active;
        tbl[0] = '{40, 1'b0, 1500};
        tbl[1] = '{39, 1'b1, 0};
        tbl[2] = '{200, 1'b0, 300};
        tbl[3] = '{201, 1'b1, 0};
        tbl[4] = '{0, 1'b1, 0};
        tbl[5] = '{120, 1'b0, 500};
        tbl[6] = '{30, 1'b1, 0};
        tbl[7] = '{250, 1'b1, 0};

        // Reset with enable high, then baseline-only stream.
        go(3);
        mon_on = 1'b1;
        peek(4);
        check("rst_rms", int'(signal_rms), 0);
        check("rst_valid", int'(signal_rms_valid), 0);
        check("rst_beat", int'(beat_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_reject", int'(bpm_reject), 0);
        check("rst_active", int'(bpm_active), 0);
        go(6);
        reset = 1'b0;
        go(50);

        // Load 120 from no period.
        t = cyc;
        b0 = t + 34;
        push_beats(b0, 500, 3);
        load(120);
        peek(t + 1);
        check("busy_first", int'(busy), 1);
        peek(t + 32);
        check("busy_last", int'(busy), 1);
        check("active_before", int'(bpm_active), 0);
        peek(t + 33);
        check("busy_done", int'(busy), 0);
        check("active_120", int'(bpm_active), 120);
        b2 = b0 + 1000;
        go(b2 + 10);

        // Change to 60 mid-period; a load during busy is refused.
        t1 = cyc;
        push_beats(b2 + 500, 1000, 3);
        load(60);
        go(t1 + 5);
        load(200);
        peek(t1 + 6);
        check("reject_busy", int'(bpm_reject), 1);
        peek(t1 + 7);
        check("reject_pulse", int'(bpm_reject), 0);
        peek(b2 + 498);
        check("active_hold120", int'(bpm_active), 120);
        peek(b2 + 499);
        check("active_60", int'(bpm_active), 60);
        bc = b2 + 2500;
        go(bc + 10);
        push_beats(bc + 1000, 333, 4);
        load(180);
        peek(bc + 998);
        check("active_hold60", int'(bpm_active), 60);
        peek(bc + 999);
        check("active_180", int'(bpm_active), 180);

        // Out-of-range loads while running.
        go(bc + 1020);
        t = cyc;
        load(30);
        peek(t + 1);
        check("reject_30", int'(bpm_reject), 1);
        go(t + 3);
        load(250);
        peek(t + 4);
        check("reject_250", int'(bpm_reject), 1);
        check("active_kept", int'(bpm_active), 180);

        // Disable during the third spike sample, then re-enable.
        go(bc + 2001);
        enable = 1'b0;
        peek(bc + 2002);
        check("disable_valid", int'(signal_rms_valid), 0);
        go(bc + 2020);
        e = cyc;
        push_beats(e + 1, 333, 2);
        enable = 1'b1;
        go(e + 344);

        // Reset in the middle of a divide.
        t = cyc;
        load(60);
        go(t + 10);
        reset = 1'b1;
        peek(t + 11);
        check("rstdiv_busy", int'(busy), 0);
        check("rstdiv_active", int'(bpm_active), 0);
        go(t + 12);
        reset = 1'b0;
        exp_active = 0;
        go(cyc + 1200);

        // Table of loads issued with the stream disabled (immediate commit).
        enable = 1'b0;
        go(cyc + 3);
        for (int i = 0; i < 8; i++) begin
            t = cyc;
            load(tbl[i].bpm);
            peek(t + 1);
            check("tbl_reject", int'(bpm_reject), int'(tbl[i].rej));
            if (!tbl[i].rej) begin
                check("tbl_busy", int'(busy), 1);
                peek(t + 33);
                check("tbl_busy_done", int'(busy), 0);
                check("tbl_active", int'(bpm_active), tbl[i].bpm);
                exp_active = tbl[i].bpm;
                go(t + 36);
                e = cyc;
                push_beats(e + 1, tbl[i].period, 3);
                enable = 1'b1;
                go(e + 2 * tbl[i].period + 10);
                enable = 1'b0;
                go(cyc + 3);
            end else begin
                check("tbl_active_kept", int'(bpm_active), exp_active);
                go(cyc + 3);
            end
        end

        check("beats_left", exp_beats.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
